// File: rtl/fb_scanout.sv
// Raster scan-out stage: walks the frame buffer in raster order on each pixel
// strobe and turns the returned 1-bit pixel into RGB with aligned sync/de.
module fb_scanout #(
  parameter int          H_ACTIVE = 640,
  parameter int          H_FP     = 16,
  parameter int          H_SYNC   = 96,
  parameter int          H_BP     = 48,
  parameter int          V_ACTIVE = 480,
  parameter int          V_FP     = 10,
  parameter int          V_SYNC   = 2,
  parameter int          V_BP     = 33,
  parameter int          ADDR_W   = 20,
  parameter logic [11:0] FG_COLOR = 12'hFFF,
  parameter logic [11:0] BG_COLOR = 12'h000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_en,
  output logic [ADDR_W-1:0] r_addr,
  input  logic              r_data,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output logic [11:0]       rgb,
  output logic              frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL + 1);
  localparam int VW      = $clog2(V_TOTAL + 1);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [HW-1:0]     h_cnt_q, h_cnt_d;
  logic [VW-1:0]     v_cnt_q, v_cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              hsync_q, hsync_d;
  logic              vsync_q, vsync_d;
  logic              de_q, de_d;
  logic [11:0]       rgb_q, rgb_d;
  logic              fs_q, fs_d;

  logic active, h_wrap, v_wrap, in_hs, in_vs;

  assign active = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
  assign h_wrap = (h_cnt_q == H_LAST);
  assign v_wrap = (v_cnt_q == V_LAST);
  assign in_hs  = (h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END);
  assign in_vs  = (v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END);

  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    addr_d  = addr_q;
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    de_d    = de_q;
    rgb_d   = rgb_q;
    fs_d    = 1'b0;
    if (pix_en) begin
      h_cnt_d = h_wrap ? '0 : h_cnt_q + HW'(1);
      if (h_wrap) v_cnt_d = v_wrap ? '0 : v_cnt_q + VW'(1);
      // Address only moves when leaving a visible pixel, so through blanking it
      // already points at the next visible one; the frame wrap reloads zero.
      if (h_wrap && v_wrap) begin
        addr_d = '0;
        fs_d   = 1'b1;
      end else if (active) begin
        addr_d = addr_q + ADDR_W'(1);
      end
      de_d    = active;
      hsync_d = ~in_hs;
      vsync_d = ~in_vs;
      rgb_d   = active ? (r_data ? FG_COLOR : BG_COLOR) : 12'h000;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      addr_q  <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      de_q    <= 1'b0;
      rgb_q   <= 12'h000;
      fs_q    <= 1'b0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      addr_q  <= addr_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      de_q    <= de_d;
      rgb_q   <= rgb_d;
      fs_q    <= fs_d;
    end
  end

  assign r_addr      = addr_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign rgb         = rgb_q;
  assign frame_start = fs_q;

endmodule

// File: doc/fb_scanout.md
# fb_scanout

Display scan-out stage that sits directly downstream of the dual-port frame-buffer RAM. Generates VGA-style raster timing from a pixel-clock enable, drives the RAM read-port address in raster order, and turns the returned 1-bit pixel into a 12-bit RGB value. Sync and data-enable are aligned with the pixel data. The frame buffer is linear: address = y*H_ACTIVE + x.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- ADDR_W, 20, frame-buffer address width; H_ACTIVE*V_ACTIVE ≤ 2^ADDR_W
- FG_COLOR, 12'hFFF, RGB output for pixel bit 1
- BG_COLOR, 12'h000, RGB output for pixel bit 0

Ports:
- clk  in  1  system clock; the block has one clock
- rst  in  1  synchronous, active-high reset
- pix_en  in  1  pixel strobe, one clk wide; period ≥ 2 clk (25 MHz from 50 MHz)
- r_addr  out  ADDR_W  RAM read-port address
- r_data  in  1  RAM read data, valid ≤ 1 clk after r_addr changes
- hsync  out  1  horizontal sync, active low
- vsync  out  1  vertical sync, active low
- de  out  1  data enable, high during visible pixels
- rgb  out  12  {R[3:0],G[3:0],B[3:0]}
- frame_start  out  1  one-clk pulse at start of each frame

## Operation
- All state updates only on clk edges where pix_en=1, except frame_start, which clears on the next clk. With pix_en held low, all outputs are frozen.
- h_cnt runs 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP. On wrap, v_cnt advances 0..V_TOTAL-1 and wraps to 0.
- Region decode:
  - active: h_cnt<H_ACTIVE and v_cnt<V_ACTIVE
  - hsync asserted: H_ACTIVE+H_FP ≤ h_cnt < H_ACTIVE+H_FP+H_SYNC
  - vsync: same form on v_cnt
- Address counter (no multiplier):
  - When (h_cnt,v_cnt) is active, r_addr = v_cnt*H_ACTIVE + h_cnt.
  - During blanking, r_addr holds the address of the next active pixel.
  - Increments by 1 on each step that leaves an active pixel.
  - Loads 0 when the counters wrap to (0,0).
- Output stage is one pix_en step behind the counters:
  - On each pix_en, de/hsync/vsync register the decoded values of the current counters.
  - rgb <= active ? (r_data ? FG_COLOR : BG_COLOR) : 12'h000.
  - r_data is sampled on the pix_en after r_addr was presented.
- frame_start pulses for one clk on the pix_en edge where the counters go from (H_TOTAL-1, V_TOTAL-1) to (0,0).

## Timing
- Reset values: h_cnt=0, v_cnt=0, r_addr=0, hsync=1, vsync=1, de=0, rgb=0, frame_start=0.
- After reset the counters start at (0,0), an active pixel, so address 0 is presented immediately.
- Latency: counter position → de/sync/rgb = exactly 1 pix_en step.
- Line boundary: after the last active pixel of line y, r_addr = (y+1)*H_ACTIVE and holds through blanking.
- Frame boundary: after the last active pixel of the last line, r_addr = H_ACTIVE*V_ACTIVE and holds through vertical blanking. It loads 0 together with the (0,0) wrap. No stale address is shown on the first pixel.
- rst asserted mid-frame: all state returns to reset values on that clk edge, regardless of pix_en. Scan restarts at (0,0) on the first pix_en after rst deasserts.
- rgb is forced to 0 whenever de=0, regardless of r_data.

## Test plan
Small-geometry parameters for all scenarios: H 8/2/2/2 (H_TOTAL 14), V 4/1/1/1 (V_TOTAL 7).

- Reset then pix_en every 2nd clk:
  - first pix_en → de=1, hsync=vsync=1, r_addr=1.
  - r_addr sequence over line 0 is 0..7 then holds 8 for 6 steps.
- Frame geometry:
  - count 98 pix_en between frame_start pulses.
  - hsync low for exactly 2 steps starting 10 steps after each line start (output-aligned).
  - vsync low for exactly 14 steps.
  - de high for 32 steps per frame.
- Pixel mapping: RAM model with bit = address[0]:
  - rgb alternates 12'h000/12'hFFF across each line.
  - rgb is 0 in all blanking steps even when r_data=1.
- Address wrap:
  - r_addr holds 32 through vertical blanking.
  - r_addr becomes 0 on the same edge frame_start pulses.
  - never exceeds 32.
- pix_en held low 20 clk mid-line: all outputs and r_addr unchanged; scan resumes at the next pixel.
- rst pulsed 1 clk at (h=5, v=2): next edge shows the reset values; frame_start occurs 98 pix_en after the release.
